// File: rtl/delay_scale_cal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delay_scale_cal_pkg
// Purpose  : Shared widths, FSM state encoding and the |x| helper for the
//            delay/scale calibration sweep.
// Revision : 1.0 - initial release
// ============================================================================
package delay_scale_cal_pkg;

  localparam int DELAY_W  = 8;
  localparam int SCALE_W  = 5;
  localparam int ERR_W    = 16;
  localparam int ENERGY_W = 32;

  // Best energy starts saturated so the first measured pair always wins.
  localparam logic [ENERGY_W-1:0] BEST_INIT = '1;

  // Fixed encodings keep the state register readable in legacy netlists.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SETTLE  = ST_SETTLE,
    S_MEASURE = ST_MEASURE,
    S_COMPARE = ST_COMPARE,
    S_DONE    = ST_DONE
  } cal_state_e;

  // Magnitude as unsigned; -32768 maps to 32768 without overflow.
  function automatic logic [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] e);
    logic [ERR_W-1:0] u;
    u = e;
    abs_err = e[ERR_W-1] ? (~u + 1'b1) : u;
  endfunction

endpackage
`default_nettype wire

// File: rtl/abs_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : abs_window_accumulator
// Purpose  : Sums |error_in| over 2**WINDOW_LOG2 strobes and flags completion.
//            Accumulator is wide enough that a full window cannot wrap.
// Revision : 1.0 - initial release
// ============================================================================
module abs_window_accumulator
  import delay_scale_cal_pkg::*;
#(
  parameter int WINDOW_LOG2 = 10
) (
  input  logic                            clk_in,
  input  logic                            reset_in,
  input  logic                            clear,
  input  logic                            ready_in,
  input  logic signed [ERR_W-1:0]         error_in,
  output logic [ERR_W+WINDOW_LOG2-1:0]    acc,
  output logic                            window_done
);

  localparam int ACC_W = ERR_W + WINDOW_LOG2;

  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic                   done_q, done_d;

  // Accumulate until the window fills; further strobes are ignored.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clear) begin
      acc_d  = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (ready_in && !done_q) begin
      acc_d  = acc_q + ACC_W'(abs_err(error_in));
      cnt_d  = cnt_q + 1'b1;
      done_d = (cnt_q == '1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign acc         = acc_q;
  assign window_done = done_q;

endmodule
`default_nettype wire

// File: rtl/delay_scale_calibrator.sv
`default_nettype none
// ============================================================================
// Module   : delay_scale_calibrator
// Purpose  : Sweeps every (delay, scale) pair, settles, measures residual
//            energy per pair and keeps the minimum-energy pair on the outputs.
//            Optional macro DELAY_SCALE_CAL_EARLY_ABORT_EN ends a window as
//            soon as it can no longer beat the current best.
// Revision : 1.0 - initial release
// ============================================================================
module delay_scale_calibrator
  import delay_scale_cal_pkg::*;
#(
  parameter int DELAY_MAX      = 31,
  parameter int SCALE_MAX      = 31,
  parameter int SETTLE_SAMPLES = 256,
  parameter int WINDOW_LOG2    = 10
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      start_in,
  input  logic                      ready_in,
  input  logic signed [ERR_W-1:0]   error_in,
  output logic [DELAY_W-1:0]        delay_out,
  output logic [SCALE_W-1:0]        scale_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [ENERGY_W-1:0]       best_energy_out
);

  localparam int ACC_W    = ERR_W + WINDOW_LOG2;
  localparam int SETTLE_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;

  localparam logic [DELAY_W-1:0]  DELAY_LAST  = DELAY_W'(DELAY_MAX);
  localparam logic [SCALE_W-1:0]  SCALE_LAST  = SCALE_W'(SCALE_MAX);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_SAMPLES - 1);

  cal_state_e            state_q, state_d;
  logic [DELAY_W-1:0]    delay_q, delay_d;
  logic [SCALE_W-1:0]    scale_q, scale_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ENERGY_W-1:0]   best_energy_q, best_energy_d;
  logic [ENERGY_W-1:0]   best_q, best_d;
  logic [DELAY_W-1:0]    best_delay_q, best_delay_d;
  logic [SCALE_W-1:0]    best_scale_q, best_scale_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;

  logic [ACC_W-1:0]      acc_val;
  logic                  window_done;
  logic                  acc_clear;
  logic                  meas_ready;
  logic [ENERGY_W-1:0]   acc_ext;
  logic                  better;
  logic                  last_pair;

  // Only strobes inside MEASURE reach the integrator; leaving MEASURE clears it.
  assign acc_clear  = (state_q != S_MEASURE);
  assign meas_ready = ready_in && (state_q == S_MEASURE);
  assign acc_ext    = ENERGY_W'(acc_val);
  assign better     = (acc_ext < best_q);
  assign last_pair  = (delay_q == DELAY_LAST) && (scale_q == SCALE_LAST);

  abs_window_accumulator #(
    .WINDOW_LOG2 (WINDOW_LOG2)
  ) u_acc (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .clear       (acc_clear),
    .ready_in    (meas_ready),
    .error_in    (error_in),
    .acc         (acc_val),
    .window_done (window_done)
  );

  // Sweep sequencer: settle, measure, compare, advance pair, finish on last.
  always_comb begin
    state_d       = state_q;
    delay_d       = delay_q;
    scale_d       = scale_q;
    busy_d        = busy_q;
    done_d        = done_q;
    best_energy_d = best_energy_q;
    best_d        = best_q;
    best_delay_d  = best_delay_q;
    best_scale_d  = best_scale_q;
    settle_cnt_d  = settle_cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          state_d      = S_SETTLE;
          delay_d      = '0;
          scale_d      = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          best_d       = BEST_INIT;
          best_delay_d = '0;
          best_scale_d = '0;
          settle_cnt_d = '0;
        end
      end

      S_SETTLE: begin
        if (ready_in) begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_d = '0;
            state_d      = S_MEASURE;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
      end

      S_MEASURE: begin
`ifdef DELAY_SCALE_CAL_EARLY_ABORT_EN
        // Energy only grows, so once it reaches best this pair cannot win.
        if (window_done || !better) state_d = S_COMPARE;
`else
        if (window_done) state_d = S_COMPARE;
`endif
      end

      S_COMPARE: begin
        // Strict less-than keeps the earliest pair on ties.
        if (better) begin
          best_d       = acc_ext;
          best_delay_d = delay_q;
          best_scale_d = scale_q;
        end
        if (last_pair) begin
          state_d       = S_DONE;
          delay_d       = best_delay_d;
          scale_d       = best_scale_d;
          best_energy_d = best_d;
          busy_d        = 1'b0;
          done_d        = 1'b1;
        end else begin
          state_d = S_SETTLE;
          if (scale_q == SCALE_LAST) begin
            scale_d = '0;
            delay_d = delay_q + 1'b1;
          end else begin
            scale_d = scale_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Registered state and outputs, synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q       <= S_IDLE;
      delay_q       <= '0;
      scale_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      best_energy_q <= '0;
      best_q        <= '0;
      best_delay_q  <= '0;
      best_scale_q  <= '0;
      settle_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      delay_q       <= delay_d;
      scale_q       <= scale_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      best_energy_q <= best_energy_d;
      best_q        <= best_d;
      best_delay_q  <= best_delay_d;
      best_scale_q  <= best_scale_d;
      settle_cnt_q  <= settle_cnt_d;
    end
  end

  assign delay_out       = delay_q;
  assign scale_out       = scale_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign best_energy_out = best_energy_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_scale_calibrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_scale_calibrator
// Purpose  : Scoreboard bench for delay_scale_calibrator with a reduced sweep
//            (4x4 pairs, 4 settle strobes, 8-strobe window, strobe every 8 clk).
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_scale_calibrator;
  import delay_scale_cal_pkg::*;

  localparam int DMAX   = 3;
  localparam int SMAX   = 3;
  localparam int SETTLE = 4;
  localparam int WLOG   = 3;
  localparam int FULL_PULSES = (DMAX + 1) * (SMAX + 1) * (SETTLE + (1 << WLOG));

  localparam int MODE_UNIQUE = 0;
  localparam int MODE_TIE    = 1;
  localparam int MODE_NEG    = 2;

  logic                clk_in   = 1'b0;
  logic                reset_in = 1'b1;
  logic                start_in = 1'b0;
  logic                ready_in = 1'b0;
  logic signed [15:0]  error_in = '0;
  logic [7:0]          delay_out;
  logic [4:0]          scale_out;
  logic                busy_out;
  logic                done_out;
  logic [31:0]         best_energy_out;

  int checks = 0;
  int errors = 0;
  int mode   = MODE_UNIQUE;

  typedef struct {
    int     d;
    int     s;
    longint e;
  } exp_t;
  exp_t sb_q[$];
  exp_t cur;

  delay_scale_calibrator #(
    .DELAY_MAX      (DMAX),
    .SCALE_MAX      (SMAX),
    .SETTLE_SAMPLES (SETTLE),
    .WINDOW_LOG2    (WLOG)
  ) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .start_in        (start_in),
    .ready_in        (ready_in),
    .error_in        (error_in),
    .delay_out       (delay_out),
    .scale_out       (scale_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .best_energy_out (best_energy_out)
  );

  always #5 clk_in = ~clk_in;

  // Residual presented for the pair currently on the outputs.
  function automatic logic signed [15:0] err_for(input int m, input int d, input int s);
    case (m)
      MODE_UNIQUE: return (d == 2 && s == 1) ? -16'sd5 : (((d + s) % 2) != 0 ? -16'sd100 : 16'sd100);
      MODE_TIE:    return ((d == 1 && s == 3) || (d == 3 && s == 0)) ? 16'sd50 : 16'sd100;
      default:     return (d == 0 && s == 0) ? 16'sd1 : 16'sh8000;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Strobe generator: one ready pulse every 8 clocks.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk_in);
      #1;
      phase    = (phase + 1) % 8;
      ready_in = (phase == 0);
      error_in = err_for(mode, int'(delay_out), int'(scale_out));
    end
  end

  // Monitor: counts strobes per sweep and scores each completed sweep.
  logic done_prev = 1'b0;
  logic busy_prev = 1'b0;
  int   pulses    = 0;
  always @(negedge clk_in) begin
    if (busy_out && !busy_prev) pulses = 0;
    if (busy_out && ready_in) pulses++;
`ifndef DELAY_SCALE_CAL_EARLY_ABORT_EN
    if (mode == MODE_NEG && busy_out && dut.state_q == S_COMPARE)
      check("neg_window_energy", longint'(dut.acc_val),
            (delay_out == 0 && scale_out == 0) ? 64'd8 : 64'd262144);
`endif
    if (done_out && !done_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        cur = sb_q.pop_front();
        check("best_delay", longint'(delay_out), longint'(cur.d));
        check("best_scale", longint'(scale_out), longint'(cur.s));
        check("best_energy", longint'(best_energy_out), cur.e);
        check("busy_at_done", longint'(busy_out), 0);
`ifdef DELAY_SCALE_CAL_EARLY_ABORT_EN
        checks++;
        if (!(pulses < FULL_PULSES)) begin
          errors++;
          $display("FAIL sweep_pulses actual=%0d expected_below=%0d", pulses, FULL_PULSES);
        end
`else
        check("sweep_pulses", longint'(pulses), longint'(FULL_PULSES));
`endif
      end
    end
    done_prev = done_out;
    busy_prev = busy_out;
  end

  task automatic pulse_start();
    @(posedge clk_in);
    #1 start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_out !== 1'b1 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (done_out !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=0 expected=1", name);
    end
    @(negedge clk_in);
  endtask

  task automatic wait_pair(input string name, input int d, input int s, input int budget);
    int n;
    n = 0;
    while (!(int'(delay_out) == d && int'(scale_out) == s && busy_out) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (!(int'(delay_out) == d && int'(scale_out) == s)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d,%0d expected=%0d,%0d", name, delay_out, scale_out, d, s);
    end
  endtask

  // Directed sequence.
  initial begin
    int n;
    repeat (3) @(posedge clk_in);
    #1 reset_in = 1'b0;
    @(negedge clk_in);
    check("rst_delay", longint'(delay_out), 0);
    check("rst_scale", longint'(scale_out), 0);
    check("rst_busy", longint'(busy_out), 0);
    check("rst_done", longint'(done_out), 0);
    check("rst_energy", longint'(best_energy_out), 0);

    // Unique minimum at (2,1).
    mode = MODE_UNIQUE;
    sb_q.push_back('{d: 2, s: 1, e: 40});
    pulse_start();
    check("start_busy", longint'(busy_out), 1);
    wait_done("unique", 4000);

    // Reset in the middle of MEASURE at pair (1,2).
    pulse_start();
    wait_pair("reset_pair", 1, 2, 4000);
    n = 0;
    while (dut.state_q != S_MEASURE && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    repeat (10) @(posedge clk_in);
    check("pre_reset_state", longint'(dut.state_q), longint'(S_MEASURE));
    #1 reset_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("mid_rst_delay", longint'(delay_out), 0);
    check("mid_rst_scale", longint'(scale_out), 0);
    check("mid_rst_busy", longint'(busy_out), 0);
    check("mid_rst_done", longint'(done_out), 0);
    check("mid_rst_energy", longint'(best_energy_out), 0);
    check("mid_rst_state", longint'(dut.state_q), longint'(S_IDLE));
    reset_in = 1'b0;

    // Restart reproduces the first result; a start during SETTLE is ignored.
    sb_q.push_back('{d: 2, s: 1, e: 40});
    pulse_start();
    wait_pair("settle_pair", 0, 1, 4000);
    pulse_start();
    check("settle_start_scale", longint'(scale_out), 1);
    check("settle_start_busy", longint'(busy_out), 1);
    wait_done("restart", 4000);

    // Start from DONE restarts the sweep; use it for the tie case.
    mode = MODE_TIE;
    sb_q.push_back('{d: 1, s: 3, e: 400});
    pulse_start();
    check("done_start_done", longint'(done_out), 0);
    check("done_start_delay", longint'(delay_out), 0);
    check("done_start_scale", longint'(scale_out), 0);
    check("done_start_busy", longint'(busy_out), 1);
    wait_done("tie", 4000);

    // Negative extremes: full-scale negative everywhere except (0,0).
    mode = MODE_NEG;
    sb_q.push_back('{d: 0, s: 0, e: 8});
    pulse_start();
    wait_done("neg", 4000);

    check("scoreboard_empty", longint'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delay_scale_calibrator.md
Name: delay_scale_calibrator

Overview:
- Sequences an automatic calibration sweep of the delay_and_scale cancellation path in the anti-noise chain.
- Steps delay_out and scale_out through every (delay, scale) pair, lets the path settle, and integrates |residual error| over a fixed sample window for each pair.
- Latches the pair with minimum residual energy and holds it on its outputs for normal operation.
- Sits between the audio sample strobe domain logic and the delay_and_scale configuration inputs (delay_in, scale_in).

Parameters:
- DELAY_MAX, 31: last delay code swept; sweep covers 0..DELAY_MAX, at most 255.
- SCALE_MAX, 31: last scale code swept; sweep covers 0..SCALE_MAX, at most 31.
- SETTLE_SAMPLES, 256: ready_in pulses ignored after each setting change.
- WINDOW_LOG2, 10: measurement window is 2**WINDOW_LOG2 ready_in pulses.

Ports:
- clk_in  input  1  system clock; the block's only clock.
- reset_in  input  1  synchronous, active-high reset.
- start_in  input  1  one-cycle pulse that starts a sweep; honoured only in IDLE or DONE.
- ready_in  input  1  one-cycle sample strobe, the same strobe that feeds delay_and_scale.
- error_in  input  16  signed residual (mic minus cancellation), valid when ready_in is high.
- delay_out  output  8  drives delay_and_scale delay_in.
- scale_out  output  5  drives delay_and_scale scale_in.
- busy_out  output  1  high while a sweep is running.
- done_out  output  1  high in DONE until the next start_in or reset.
- best_energy_out  output  32  minimum window energy found, zero-extended.

Behaviour:
- Reset (synchronous, active-high): state IDLE; delay_out=0, scale_out=0, busy_out=0, done_out=0, best_energy_out=0; all counters cleared.
- FSM states: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- IDLE/DONE + start_in: next cycle enters SETTLE.
  - delay_out=0, scale_out=0, busy_out=1, done_out=0.
  - Best energy register set to all-ones; best pair set to (0,0).
- SETTLE: counts ready_in pulses. After SETTLE_SAMPLES pulses, go to MEASURE with the accumulator cleared.
- MEASURE: on each ready_in, acc += |error_in|.
  - |-32768| = 32768 as 16-bit unsigned; no saturation is needed (acc width 16+WINDOW_LOG2).
  - After 2**WINDOW_LOG2 pulses, go to COMPARE.
- COMPARE (exactly 1 cycle):
  - If acc < best (strictly less), best := acc and best pair := current pair. Ties keep the earlier pair.
  - Then advance the pair. Scale is the inner loop: scale increments; at SCALE_MAX it wraps to 0 and delay increments.
  - If the pair was (DELAY_MAX, SCALE_MAX), go to DONE; otherwise go to SETTLE with the new pair on the outputs.
- DONE: delay_out/scale_out = best pair; best_energy_out = best; busy_out=0; done_out=1.
- Outputs change only on COMPARE exit or on entry to IDLE/SETTLE/DONE. Each output is held constant through every SETTLE+MEASURE interval.
- start_in while busy: ignored.
- start_in and ready_in in the same cycle: start is taken; that sample is not counted.
- ready_in in COMPARE: not counted; it does not belong to the next setting's settle period.
- Reset mid-sweep: immediate return to IDLE with reset values; the partial best is discarded.
- Total sweep length: (DELAY_MAX+1)*(SCALE_MAX+1)*(SETTLE_SAMPLES+2**WINDOW_LOG2) ready pulses, plus one COMPARE cycle per pair.

Optional Feature:
- Macro: DELAY_SCALE_CAL_EARLY_ABORT_EN.
- Defined: in MEASURE, once acc >= best, go straight to COMPARE. No update occurs and the pair advances. This shortens the sweep.
- Undefined: every pair measures its full window.
- The final best pair and best_energy_out are identical either way; only the sweep duration differs.

Decomposition:
- Package delay_scale_cal_pkg holds:
  - the state enum typedef;
  - constants DELAY_W=8, SCALE_W=5, ERR_W=16, ENERGY_W=32;
  - the all-ones initial-best constant.
- One sub-module, abs_window_accumulator, takes clk_in, reset_in, clear, ready_in and error_in and returns acc plus a window_done flag. The FSM stays in the top module.

Test Plan:
All cases use DELAY_MAX=3, SCALE_MAX=3, SETTLE_SAMPLES=4, WINDOW_LOG2=3 unless stated, with ready_in pulsed every 8 clocks.
- Unique minimum: bench drives |error_in|=100 except 5 when (delay_out,scale_out)=(2,1).
  - Expect done_out=1, delay_out=2, scale_out=1, best_energy_out=40.
  - busy_out high for 16*12 = 192 ready pulses plus 16 COMPARE cycles.
- Tie: error=50 at both (1,3) and (3,0), 100 elsewhere -> best pair (1,3), best_energy_out=400.
- Negative extremes: error_in=-32768 everywhere except +1 at (0,0) -> pair (0,0), best_energy_out=8. Also check the energy at other pairs is 262144 internally, with no wrap.
- Reset and restart: assert reset_in mid-MEASURE at pair (1,2).
  - Next cycle: all outputs 0, state IDLE.
  - A later start_in reruns the full sweep and reproduces the first test's result.
- Start handling: start_in pulsed during SETTLE is ignored (no restart). start_in in DONE restarts: done_out drops the next cycle and delay_out=0.
- With DELAY_SCALE_CAL_EARLY_ABORT_EN defined, rerun the first test.
  - Expect the same (2,1), 40 result.
  - Sweep completes in fewer ready pulses than 192.
